// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  : operand forwarding select (regfile / ResultW / ALUResultM)
//   hz_state_t : data-memory handshake state
//   fwd_sel()  : forwarding priority for one E-stage source operand
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

    // M has priority over W because it holds the younger result.
    // R15 goes through the same comparison as any other register.
    function automatic fwd_sel_t fwd_sel(input logic [3:0] ra,
                                         input logic       rw_m,
                                         input logic [3:0] wa_m,
                                         input logic       rw_w,
                                         input logic [3:0] wa_w);
        if (rw_m && (ra == wa_m))      return FWD_M;
        else if (rw_w && (ra == wa_w)) return FWD_W;
        else                           return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Data-memory request/ready handshake for the M stage.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   mem_access_i      : M-stage instruction accesses data memory
//   dmem_ready_i      : memory completes the access this cycle
//   dmem_req_o        : request strobe (combinational)
//   mem_stall_o       : freeze the pipeline this cycle (combinational)
//   mem_timeout_o     : one-cycle abort pulse (combinational)
module mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_access_i,
    input  logic dmem_ready_i,
    output logic dmem_req_o,
    output logic mem_stall_o,
    output logic mem_timeout_o
);

    localparam int WCW = $clog2(TIMEOUT) + 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT - 1);

    hz_state_t      state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // The wait counter holds the number of stalled cycles already spent on
    // the current access, so the cycle that sees WCNT_LAST is the abort cycle.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        dmem_req_o    = 1'b0;
        mem_stall_o   = 1'b0;
        mem_timeout_o = 1'b0;
        case (state_q)
            RUN: begin
                dmem_req_o = mem_access_i;
                if (mem_access_i && !dmem_ready_i) begin
                    mem_stall_o = 1'b1;
                    state_d     = MEM_WAIT;
                    wcnt_d      = WCW'(1);
                end
            end
            MEM_WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ready_i) begin
                    state_d = RUN;
                end else if (wcnt_q == WCNT_LAST) begin
                    mem_timeout_o = 1'b1;
                    state_d       = RUN;
                end else begin
                    mem_stall_o = 1'b1;
                    wcnt_d      = wcnt_q + WCW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   Ra1E/Ra2E, Ra1D/Ra2D            : E/D-stage source registers
//   WA3E/WA3M/WA3W, RegWriteM/W     : destinations and write enables
//   MemtoRegE                       : E-stage load
//   PCSrcD/E/M/W, BranchTakenE      : PC-writing instructions, taken branch
//   MemAccessM, dmem_ready, dmem_req: data-memory handshake
//   ForwardAE/BE                    : operand forwarding selects
//   StallF/D/E/M, FlushD/E/W        : pipeline register controls
//   mem_timeout                     : access abort pulse
//   stall_cycles                    : saturating memory-stall cycle count
// All controls are combinational and forced low while reset is high.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Ra1E,
    input  logic [3:0]       Ra2E,
    input  logic [3:0]       Ra1D,
    input  logic [3:0]       Ra2D,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemAccessM,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    logic mem_stall, mem_tmo, mem_req;
    logic ldr_stall, pc_pend;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_mem_wait (
        .clk           (clk),
        .reset         (reset),
        .mem_access_i  (MemAccessM),
        .dmem_ready_i  (dmem_ready),
        .dmem_req_o    (mem_req),
        .mem_stall_o   (mem_stall),
        .mem_timeout_o (mem_tmo)
    );

    assign ldr_stall = MemtoRegE && ((Ra1D == WA3E) || (Ra2D == WA3E));
    assign pc_pend   = PCSrcD | PCSrcE | PCSrcM;

    always_comb begin
        dmem_req    = 1'b0;
        ForwardAE   = FWD_RF;
        ForwardBE   = FWD_RF;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        mem_timeout = 1'b0;
        if (!reset) begin
            dmem_req    = mem_req;
            mem_timeout = mem_tmo;
            ForwardAE   = fwd_sel(Ra1E, RegWriteM, WA3M, RegWriteW, WA3W);
            ForwardBE   = fwd_sel(Ra2E, RegWriteM, WA3M, RegWriteW, WA3W);
            if (mem_stall) begin
                // Freeze everything up to M; bubble W so the frozen M
                // instruction is not retired twice. Flushes of D/E wait for
                // release since their causes stay frozen in place.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = ldr_stall | pc_pend;
                StallD = ldr_stall;
                FlushD = pc_pend | PCSrcW | BranchTakenE;
                FlushE = ldr_stall | BranchTakenE;
            end
        end
    end

    assign cnt_d = (mem_stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_cycles = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] Ra1E, Ra2E, Ra1D, Ra2D, WA3E, WA3M, WA3W;
    logic RegWriteM, RegWriteW, MemtoRegE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic MemAccessM, dmem_ready, dmem_req;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
    logic [CW-1:0] stall_cycles;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Ra1E(Ra1E), .Ra2E(Ra2E), .Ra1D(Ra1D), .Ra2D(Ra2D),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemAccessM(MemAccessM),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: "waiting" = an access has been stalled and is still
    // outstanding; "elapsed" = stalled cycles spent on it so far.
    bit m_wait;
    int m_elapsed;
    int m_scnt;
    bit m_stall, m_tmo;

    function automatic int ref_fwd(input logic [3:0] ra);
        if (RegWriteM && ra == WA3M) return 2;
        if (RegWriteW && ra == WA3W) return 1;
        return 0;
    endfunction

    task automatic model_check();
        bit ldr, pend;
        int es, ef;
        if (reset) begin
            m_stall = 0;
            m_tmo   = 0;
            chk("rst_outs", 32'({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                                 FlushD, FlushE, FlushW, mem_timeout, dmem_req}), 0);
            chk("rst_cnt", 32'(stall_cycles), 0);
            return;
        end
        ldr  = MemtoRegE && (Ra1D == WA3E || Ra2D == WA3E);
        pend = PCSrcD || PCSrcE || PCSrcM;
        if (!m_wait) begin
            m_stall = MemAccessM && !dmem_ready;
            m_tmo   = 0;
        end else begin
            m_tmo   = !dmem_ready && (m_elapsed == TO - 1);
            m_stall = !dmem_ready && !m_tmo;
        end
        es = m_stall ? 15 : ((ldr || pend) ? 8 : 0) + (ldr ? 4 : 0);
        ef = m_stall ? 1  : ((pend || PCSrcW || BranchTakenE) ? 4 : 0)
                          + ((ldr || BranchTakenE) ? 2 : 0);
        chk("fwdA", 32'(ForwardAE), ref_fwd(Ra1E));
        chk("fwdB", 32'(ForwardBE), ref_fwd(Ra2E));
        chk("stall_FDEM", 32'({StallF, StallD, StallE, StallM}), es);
        chk("flush_DEW", 32'({FlushD, FlushE, FlushW}), ef);
        chk("dmem_req", 32'(dmem_req), (m_wait || MemAccessM) ? 1 : 0);
        chk("timeout", 32'(mem_timeout), m_tmo ? 1 : 0);
        chk("stall_cycles", 32'(stall_cycles), m_scnt);
    endtask

    task automatic model_update();
        if (reset) begin
            m_wait = 0; m_elapsed = 0; m_scnt = 0;
            return;
        end
        if (m_stall && m_scnt < CMAX) m_scnt++;
        if (!m_wait) begin
            if (MemAccessM && !dmem_ready) begin
                m_wait = 1; m_elapsed = 1;
            end
        end else if (dmem_ready || m_tmo) begin
            m_wait = 0;
        end else begin
            m_elapsed++;
        end
    endtask

    // Inputs are changed just after a rising edge; outputs are compared
    // 1 time unit later, well before the next edge.
    task automatic cycle();
        #1 model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_in();
        {Ra1E, Ra2E, Ra1D, Ra2D} = '0;
        WA3E = 4'd9; WA3M = 4'd10; WA3W = 4'd11;
        {RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
        {BranchTakenE, MemAccessM, dmem_ready} = '0;
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        m_wait = 0; m_elapsed = 0; m_scnt = 0;
        reset = 1'b1;
        clear_in();
        MemAccessM = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        clear_in();
        cycle();

        // Forwarding priority
        RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; Ra1E = 3; Ra2E = 5;
        #1 chk("dir_fwdA_M", 32'(ForwardAE), 2);
        chk("dir_fwdB_RF", 32'(ForwardBE), 0);
        cycle();
        RegWriteM = 0;
        #1 chk("dir_fwdA_W", 32'(ForwardAE), 1);
        cycle();
        clear_in();

        // Load-use
        MemtoRegE = 1; WA3E = 2; Ra2D = 2;
        #1 chk("dir_ldr", 32'({StallF, StallD, FlushE, FlushD}), 4'b1110);
        cycle();
        MemtoRegE = 0;
        #1 chk("dir_ldr_off", 32'({StallF, StallD, FlushE, FlushD}), 0);
        cycle();

        // Branch / PC pending
        BranchTakenE = 1;
        #1 chk("dir_br", 32'({FlushD, FlushE}), 2'b11);
        cycle();
        BranchTakenE = 0; PCSrcM = 1;
        #1 chk("dir_pcm", 32'({StallF, FlushD}), 2'b11);
        cycle();
        PCSrcM = 0; PCSrcW = 1;
        #1 chk("dir_pcw", 32'({StallF, FlushD}), 2'b01);
        cycle();
        clear_in();

        // Three-cycle memory wait with a taken branch held in E
        MemAccessM = 1; BranchTakenE = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dir_wait_stall", 32'({StallF, StallD, StallE, StallM, FlushW}), 5'b11111);
            chk("dir_wait_flushDE", 32'({FlushD, FlushE}), 0);
            cycle();
        end
        dmem_ready = 1;
        #1 chk("dir_rel_stall", 32'({StallE, StallM, FlushW}), 0);
        chk("dir_rel_flushDE", 32'({FlushD, FlushE}), 2'b11);
        cycle();
        BranchTakenE = 0;
        cycle();                       // back-to-back zero-wait access
        MemAccessM = 0;
        #1 chk("dir_cnt3", 32'(stall_cycles), 3);
        cycle();

        // Timeout with ready held low
        MemAccessM = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("dir_to_stall", 32'(StallM), (i < 3) ? 1 : 0);
            chk("dir_to_pulse", 32'(mem_timeout), (i == 3) ? 1 : 0);
            cycle();
        end
        MemAccessM = 0;
        #1 chk("dir_to_run", 32'({dmem_req, StallM}), 0);
        chk("dir_cnt6", 32'(stall_cycles), 6);
        cycle();

        // Reset in the middle of a wait
        MemAccessM = 1;
        cycle();
        cycle();
        reset = 1;
        #1 chk("dir_rst_req", 32'(dmem_req), 0);
        chk("dir_rst_cnt", 32'(stall_cycles), 0);
        chk("dir_rst_to", 32'(mem_timeout), 0);
        cycle();
        reset = 0; MemAccessM = 0;
        #1 chk("dir_post_rst", 32'({dmem_req, StallM, FlushW}), 0);
        cycle();

        // Counter saturation
        MemAccessM = 1; dmem_ready = 0;
        for (int i = 0; i < 30; i++) cycle();
        MemAccessM = 0;
        #1 chk("dir_sat", 32'(stall_cycles), CMAX);
        cycle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            Ra1E = rreg(); Ra2E = rreg(); Ra1D = rreg(); Ra2D = rreg();
            WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            PCSrcD       = ($urandom_range(0, 7) == 0);
            PCSrcE       = ($urandom_range(0, 7) == 0);
            PCSrcM       = ($urandom_range(0, 7) == 0);
            PCSrcW       = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            MemAccessM   = 1'($urandom_range(0, 1));
            dmem_ready   = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
